// File: rtl/reg_writeback_pkg.sv
// Shared widths and the load-return queue entry for the writeback block.
package reg_writeback_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 3;
    localparam int NUM_REGS   = 8;
    localparam int LQ_DEPTH   = 4;
    localparam int PTR_W      = $clog2(LQ_DEPTH);
    localparam int CNT_W      = PTR_W + 1;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] dest;
        logic [DATA_W-1:0]     data;
    } lqEntry_t;

endpackage

// File: rtl/reg_writeback_load_queue.sv
// Load-return FIFO: one push, up to two pops per cycle, head/second peek
// and a mask of destination registers still waiting in the queue.
module wb_load_queue
    import reg_writeback_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                push,
    input  lqEntry_t            pushEntry,
    input  logic [1:0]          popCnt,
    output lqEntry_t            headEntry,
    output lqEntry_t            nextEntry,
    output logic [CNT_W-1:0]    count,
    output logic [NUM_REGS-1:0] pending
);

    lqEntry_t         mem [LQ_DEPTH];
    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W-1:0] wrPtr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + PTR_W'(1);
            end
            rdPtr <= rdPtr + PTR_W'(popCnt);
            count <= count + CNT_W'(push) - CNT_W'(popCnt);
        end
    end

    // Storage needs no reset; validity comes from count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wrPtr] <= pushEntry;
        end
    end

    assign headEntry = mem[rdPtr];
    assign nextEntry = mem[rdPtr + PTR_W'(1)];

    always_comb begin
        pending = '0;
        for (int i = 0; i < LQ_DEPTH; i++) begin
            if (CNT_W'(i) < count) begin
                pending[mem[rdPtr + PTR_W'(i)].dest] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_writeback.sv
// Two-port register writeback: staged ALU results own their port, queued
// load returns fill free ports, and the younger port wins on a dest clash.
module reg_writeback
    import reg_writeback_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  aluValid1,
    input  logic                  aluValid2,
    input  logic [REG_ADDR_W-1:0] aluDest1,
    input  logic [REG_ADDR_W-1:0] aluDest2,
    input  logic [DATA_W-1:0]     aluData1,
    input  logic [DATA_W-1:0]     aluData2,
    input  logic                  ldValid,
    input  logic [REG_ADDR_W-1:0] ldDest,
    input  logic [DATA_W-1:0]     ldData,
    output logic                  ldReady,
    output logic                  regWrite1,
    output logic                  regWrite2,
    output logic [REG_ADDR_W-1:0] destReg1,
    output logic [REG_ADDR_W-1:0] destReg2,
    output logic [DATA_W-1:0]     writeData1,
    output logic [DATA_W-1:0]     writeData2,
    output logic [NUM_REGS-1:0]   pending
);

    logic             slot1Valid;
    logic             slot2Valid;
    lqEntry_t         slot1;
    lqEntry_t         slot2;
    logic             alive;

    lqEntry_t         headEntry;
    lqEntry_t         nextEntry;
    logic [CNT_W-1:0] lqCount;
    logic [1:0]       popCnt;
    logic             push;

    logic             ld1;
    logic             ld2;
    logic             en1;
    logic             en2;
    logic             collide;
    lqEntry_t         port1;
    lqEntry_t         port2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot1Valid <= 1'b0;
            slot2Valid <= 1'b0;
            slot1      <= '0;
            slot2      <= '0;
            alive      <= 1'b0;
        end else begin
            slot1Valid <= aluValid1;
            slot2Valid <= aluValid2;
            slot1      <= '{dest: aluDest1, data: aluData1};
            slot2      <= '{dest: aluDest2, data: aluData2};
            alive      <= 1'b1;
        end
    end

    // Held low through reset and until the first edge after it.
    assign ldReady = alive && (lqCount < CNT_W'(LQ_DEPTH));
    assign push    = ldValid && ldReady;

    always_comb begin
        ld1 = !slot1Valid && (lqCount != '0);
        ld2 = !slot2Valid &&
              (lqCount > (ld1 ? CNT_W'(1) : CNT_W'(0)));
        en1 = slot1Valid || ld1;
        en2 = slot2Valid || ld2;

        port1 = ld1 ? headEntry : slot1;
        if (slot2Valid) begin
            port2 = slot2;
        end else begin
            port2 = ld1 ? nextEntry : headEntry;
        end

        // A discarded port-1 load still leaves the queue.
        collide = en1 && en2 && (port1.dest == port2.dest);
        popCnt  = {1'b0, ld1} + {1'b0, ld2};

        regWrite1  = en1 && !collide;
        regWrite2  = en2;
        destReg1   = regWrite1 ? port1.dest : '0;
        writeData1 = regWrite1 ? port1.data : '0;
        destReg2   = regWrite2 ? port2.dest : '0;
        writeData2 = regWrite2 ? port2.data : '0;
    end

    wb_load_queue u_lq (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pushEntry ('{dest: ldDest, data: ldData}),
        .popCnt    (popCnt),
        .headEntry (headEntry),
        .nextEntry (nextEntry),
        .count     (lqCount),
        .pending   (pending)
    );

endmodule

// File: tb/tb_reg_writeback.sv
// Bench for reg_writeback: queue-level model checked every cycle plus
// hand-computed expectations for the directed scenarios.
`timescale 1ns/1ps
module tb_reg_writeback;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        aluValid1 = 1'b0;
    logic        aluValid2 = 1'b0;
    logic [2:0]  aluDest1 = '0;
    logic [2:0]  aluDest2 = '0;
    logic [31:0] aluData1 = '0;
    logic [31:0] aluData2 = '0;
    logic        ldValid = 1'b0;
    logic [2:0]  ldDest = '0;
    logic [31:0] ldData = '0;
    logic        ldReady;
    logic        regWrite1;
    logic        regWrite2;
    logic [2:0]  destReg1;
    logic [2:0]  destReg2;
    logic [31:0] writeData1;
    logic [31:0] writeData2;
    logic [7:0]  pending;

    always #5 clk = ~clk;

    reg_writeback dut (
        .clk        (clk),
        .reset      (reset),
        .aluValid1  (aluValid1),
        .aluValid2  (aluValid2),
        .aluDest1   (aluDest1),
        .aluDest2   (aluDest2),
        .aluData1   (aluData1),
        .aluData2   (aluData2),
        .ldValid    (ldValid),
        .ldDest     (ldDest),
        .ldData     (ldData),
        .ldReady    (ldReady),
        .regWrite1  (regWrite1),
        .regWrite2  (regWrite2),
        .destReg1   (destReg1),
        .destReg2   (destReg2),
        .writeData1 (writeData1),
        .writeData2 (writeData2),
        .pending    (pending)
    );

    typedef struct {
        logic [2:0]  dest;
        logic [31:0] data;
    } ent_t;

    typedef struct {
        logic        rw1;
        logic [2:0]  d1;
        logic [31:0] w1;
        logic        rw2;
        logic [2:0]  d2;
        logic [31:0] w2;
        logic [7:0]  pend;
        logic        rdy;
        int          pops;
    } exp_t;

    ent_t mQ[$];
    logic mS1v = 1'b0;
    logic mS2v = 1'b0;
    ent_t mS1;
    ent_t mS2;
    logic mAlive = 1'b0;

    int nCmp = 0;
    int nErr = 0;

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        nCmp++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Writes this cycle: each port takes its ALU result, else the oldest
    // unclaimed load; equal destinations keep only the port-2 write.
    function automatic exp_t model();
        exp_t        e;
        int          qi;
        logic        v1;
        logic        v2;
        ent_t        p1;
        ent_t        p2;
        e  = '{default: '0};
        qi = 0;
        v1 = mS1v;
        p1 = mS1;
        v2 = mS2v;
        p2 = mS2;
        if (!v1 && qi < mQ.size()) begin
            v1 = 1'b1;
            p1 = mQ[qi];
            qi++;
        end
        if (!v2 && qi < mQ.size()) begin
            v2 = 1'b1;
            p2 = mQ[qi];
            qi++;
        end
        if (v1 && v2 && p1.dest == p2.dest) v1 = 1'b0;
        if (v1) begin
            e.rw1 = 1'b1;
            e.d1  = p1.dest;
            e.w1  = p1.data;
        end
        if (v2) begin
            e.rw2 = 1'b1;
            e.d2  = p2.dest;
            e.w2  = p2.data;
        end
        e.pops = qi;
        foreach (mQ[i]) e.pend[mQ[i].dest] = 1'b1;
        e.rdy = mAlive && (mQ.size() < 4);
        return e;
    endfunction

    always @(posedge clk or posedge reset) begin : upd
        exp_t e;
        if (reset) begin
            mQ.delete();
            mS1v   = 1'b0;
            mS2v   = 1'b0;
            mAlive = 1'b0;
        end else begin
            e = model();
            for (int i = 0; i < e.pops; i++) void'(mQ.pop_front());
            if (ldValid && e.rdy) mQ.push_back('{dest: ldDest, data: ldData});
            mS1v   = aluValid1;
            mS2v   = aluValid2;
            mS1    = '{dest: aluDest1, data: aluData1};
            mS2    = '{dest: aluDest2, data: aluData2};
            mAlive = 1'b1;
        end
    end

    always @(negedge clk) begin : cmp
        exp_t e;
        e = model();
        check("mdl.regWrite1", regWrite1, e.rw1);
        check("mdl.destReg1", destReg1, e.d1);
        check("mdl.writeData1", writeData1, e.w1);
        check("mdl.regWrite2", regWrite2, e.rw2);
        check("mdl.destReg2", destReg2, e.d2);
        check("mdl.writeData2", writeData2, e.w2);
        check("mdl.pending", pending, e.pend);
        check("mdl.ldReady", ldReady, e.rdy);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setAlu(input logic v1, input logic [2:0] d1,
                          input logic [31:0] x1, input logic v2,
                          input logic [2:0] d2, input logic [31:0] x2);
        aluValid1 = v1;
        aluDest1  = d1;
        aluData1  = x1;
        aluValid2 = v2;
        aluDest2  = d2;
        aluData2  = x2;
    endtask

    task automatic setLd(input logic v, input logic [2:0] d,
                         input logic [31:0] x);
        ldValid = v;
        ldDest  = d;
        ldData  = x;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        tick();
        check("rst.regWrite1", regWrite1, 0);
        check("rst.regWrite2", regWrite2, 0);
        check("rst.ldReady", ldReady, 0);
        check("rst.pending", pending, 0);
        reset = 1'b0;
        tick();
        check("rel.ldReady", ldReady, 1);

        // Two independent ALU results.
        setAlu(1, 3'd3, 32'h11, 1, 3'd5, 32'h22);
        tick();
        check("alu.rw1", regWrite1, 1);
        check("alu.dest1", destReg1, 3);
        check("alu.data1", writeData1, 32'h11);
        check("alu.rw2", regWrite2, 1);
        check("alu.dest2", destReg2, 5);
        check("alu.data2", writeData2, 32'h22);

        // ALU vs ALU on the same register.
        setAlu(1, 3'd4, 32'hAA, 1, 3'd4, 32'hBB);
        tick();
        check("aa.rw1", regWrite1, 0);
        check("aa.dest1", destReg1, 0);
        check("aa.data1", writeData1, 0);
        check("aa.rw2", regWrite2, 1);
        check("aa.dest2", destReg2, 4);
        check("aa.data2", writeData2, 32'hBB);

        // Fill the queue while both ports are busy, then drain.
        setAlu(1, 3'd0, 32'hC0, 1, 3'd7, 32'hC7);
        for (int i = 1; i <= 4; i++) begin
            setLd(1, 3'(i), 32'h100 + 32'(i));
            tick();
        end
        check("fill.ldReady", ldReady, 0);
        check("fill.pending", pending, 8'h1E);
        setLd(0, 3'd0, 32'h0);
        setAlu(0, 3'd0, 32'h0, 0, 3'd0, 32'h0);
        tick();
        check("dr1.dest1", destReg1, 1);
        check("dr1.data1", writeData1, 32'h101);
        check("dr1.dest2", destReg2, 2);
        check("dr1.data2", writeData2, 32'h102);
        check("dr1.ldReady", ldReady, 0);
        tick();
        check("dr2.dest1", destReg1, 3);
        check("dr2.dest2", destReg2, 4);
        check("dr2.ldReady", ldReady, 1);
        check("dr2.pending", pending, 8'h18);
        tick();
        check("dr3.pending", pending, 0);
        check("dr3.rw1", regWrite1, 0);

        // Queued load vs pipe-2 ALU result on the same register.
        setLd(1, 3'd6, 32'h77);
        setAlu(0, 3'd0, 32'h0, 1, 3'd6, 32'h99);
        tick();
        check("la.rw1", regWrite1, 0);
        check("la.rw2", regWrite2, 1);
        check("la.dest2", destReg2, 6);
        check("la.data2", writeData2, 32'h99);
        setLd(0, 3'd0, 32'h0);
        setAlu(0, 3'd0, 32'h0, 0, 3'd0, 32'h0);
        tick();
        check("la.pending", pending, 0);
        check("la.empty", regWrite1 | regWrite2, 0);

        // Full queue with a load held until space opens.
        setAlu(1, 3'd0, 32'hA0, 1, 3'd7, 32'hB0);
        setLd(1, 3'd1, 32'h201);
        tick();
        setLd(1, 3'd2, 32'h202);
        tick();
        setLd(1, 3'd3, 32'h203);
        tick();
        setLd(1, 3'd5, 32'h205);
        tick();
        setAlu(0, 3'd0, 32'h0, 1, 3'd7, 32'hB0);
        setLd(1, 3'd6, 32'h66);
        tick();
        check("full.ldReady", ldReady, 0);
        check("full.dest1", destReg1, 1);
        check("full.dest2", destReg2, 7);
        tick();
        check("full.ready2", ldReady, 1);
        check("full.pend2", pending, 8'h2C);
        tick();
        check("full.pend3", pending, 8'h68);
        check("full.dest1b", destReg1, 3);
        setLd(0, 3'd0, 32'h0);

        // Asynchronous reset mid-drain.
        #2;
        reset = 1'b1;
        #1;
        check("ar.rw1", regWrite1, 0);
        check("ar.rw2", regWrite2, 0);
        check("ar.dest1", destReg1, 0);
        check("ar.data1", writeData1, 0);
        check("ar.pending", pending, 0);
        check("ar.ldReady", ldReady, 0);
        setAlu(0, 3'd0, 32'h0, 0, 3'd0, 32'h0);
        tick();
        reset = 1'b0;
        tick();
        check("ar.ready", ldReady, 1);
        check("ar.pend", pending, 0);
        check("ar.nowr", regWrite1 | regWrite2, 0);

        // Queued load on port 2 beats an ALU result on port 1.
        setAlu(1, 3'd2, 32'h300, 1, 3'd3, 32'h301);
        setLd(1, 3'd5, 32'h55);
        tick();
        setAlu(1, 3'd2, 32'h300, 0, 3'd0, 32'h0);
        setLd(1, 3'd2, 32'h56);
        tick();
        check("mx.dest1", destReg1, 2);
        check("mx.data1", writeData1, 32'h300);
        check("mx.dest2", destReg2, 5);
        check("mx.data2", writeData2, 32'h55);
        setLd(0, 3'd0, 32'h0);
        tick();
        check("mx.rw1", regWrite1, 0);
        check("mx.dest2b", destReg2, 2);
        check("mx.data2b", writeData2, 32'h56);
        setAlu(0, 3'd0, 32'h0, 0, 3'd0, 32'h0);
        tick();
        tick();
        check("mx.pending", pending, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule

// File: doc/reg_writeback.md
REG_WRITEBACK -- requirements
Module: reg_writeback

Interface
REQ-001 Parameters: DATA_W, 32, register data width; REG_ADDR_W, 3, destination index width (8 registers); LQ_DEPTH, 4, load-return queue entries.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 aluValid1, aluValid2  input  1 each  pipe-1 / pipe-2 result valid; pipe 2 is younger in program order.
REQ-005 aluDest1, aluDest2  input  REG_ADDR_W each  result destination register.
REQ-006 aluData1, aluData2  input  DATA_W each  result data.
REQ-007 ldValid  input  1  load-return valid; ldDest input REG_ADDR_W; ldData input DATA_W.
REQ-008 ldReady  output  1  load queue can accept; transfer when ldValid && ldReady at a rising edge.
REQ-009 regWrite1, regWrite2  output  1 each  register-file write enables.
REQ-010 destReg1, destReg2  output  REG_ADDR_W each  write indices.
REQ-011 writeData1, writeData2  output  DATA_W each  write data.
REQ-012 pending  output  8  bit r set while any queued load targets register r.

Function
REQ-013 ALU results SHALL be registered: input valid at edge N drives port 1 (pipe 1) / port 2 (pipe 2) during cycle N+1; latency exactly 1 cycle.
REQ-014 A port is free in a cycle when its ALU stage slot is invalid.
REQ-015 The load queue is a FIFO; each cycle it SHALL pop the head onto the free port (port 1 preferred), then a second entry onto the remaining free port, maximum two pops per cycle.
REQ-016 A pushed entry SHALL be eligible for draining no earlier than the cycle after its push edge.
REQ-017 ldReady SHALL equal (count < LQ_DEPTH) from registered count; no same-cycle pop bypass when full.
REQ-018 Simultaneous push and pop SHALL keep count consistent (count_next = count + push - pops); pointers wrap modulo LQ_DEPTH.
REQ-019 Same-cycle collision: if both ports are enabled with equal dest, regWrite1 SHALL be suppressed and port 2 written (younger wins).
REQ-020 If the colliding port-1 write is a load entry, that entry SHALL still be popped (discarded); ALU-vs-ALU collision discards the pipe-1 result.
REQ-021 pending SHALL be the OR of one-hot decodes of all valid queue entries' dest, from registered state; upstream stalls ALU issue to pending registers (not checked here).
REQ-022 Write outputs with regWrite low SHALL drive dest 0 and data 0.
REQ-023 Outputs SHALL be driven from registered state; no combinational path from ald/ld inputs to regWrite/dest/writeData.

Reset
REQ-024 While reset is high: regWrite1/2 = 0, destReg1/2 = 0, writeData1/2 = 0, pending = 0, ldReady = 0, queue count and pointers = 0; ALU stage slots invalid.
REQ-025 ldReady SHALL rise in the first cycle after reset deasserts; reset mid-operation discards all queued loads and staged results without any write.

Structure
REQ-026 Shared package SHALL hold DATA_W, REG_ADDR_W, NUM_REGS = 8, LQ_DEPTH and the queue entry struct {dest, data}.
REQ-027 Sub-module wb_load_queue SHALL implement the FIFO (push, pop count 0..2, head/second-entry peek, count, pending mask); port allocation and collision logic stay in reg_writeback.

Verification
REQ-028 aluValid1=1 dest 3 data 0x11, aluValid2=1 dest 5 data 0x22 at edge N -> cycle N+1: regWrite1=1 dest 3 data 0x11, regWrite2=1 dest 5 data 0x22.
REQ-029 Both ALU dest 4 (0xAA pipe1, 0xBB pipe2) -> next cycle regWrite1=0, regWrite2=1 dest 4 data 0xBB.
REQ-030 Push 4 loads (dest 1..4) with ALU both ports busy -> ldReady=0 after 4th, pending=0x1E; release ports -> two writes per cycle (1,2 then 3,4), pending back to 0, ldReady=1 after first drain cycle.
REQ-031 Queued load dest 6 data 0x77, pipe-2 ALU dest 6 data 0x99, pipe 1 idle -> single cycle: regWrite1=0, regWrite2=1 data 0x99, queue empty next cycle.
REQ-032 Full queue, ldValid held high while one entry drains -> no push that edge, push accepted next edge; count never exceeds 4.
REQ-033 Assert reset asynchronously mid-drain with 3 entries queued -> outputs 0 immediately, no write; after release ldReady=1, pending=0.
